// File: rtl/fib_pkg.sv
// Shared types and helpers for the 4-bit wrapping Fibonacci checker.
// Holds the sample width, wrap term, FSM state enum and model update rule.
package fib_pkg;

    localparam int FIB_W = 4;
    localparam logic [FIB_W-1:0] FIB_WRAP_TERM = 4'h8;

    typedef enum logic {
        HUNT  = 1'b0,
        CHECK = 1'b1
    } state_e;

    // One generator step: returns {a, b} after the advance.
    function automatic logic [2*FIB_W-1:0] fib_next(
        input logic [FIB_W-1:0] a,
        input logic [FIB_W-1:0] b
    );
        logic [FIB_W-1:0] one;
        one = {{(FIB_W-1){1'b0}}, 1'b1};
        if (b[FIB_W-1]) begin
            return {one, {FIB_W{1'b0}}};
        end
        return {a + b, a};
    endfunction

endpackage

// File: rtl/fib_ref_gen.sv
// Reference model registers ma/mb for the Fibonacci checker.
// Ports: clk, rst (async active-low), load, adv in; mb out.
module fib_ref_gen
    import fib_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             adv,
    output logic [FIB_W-1:0] mb
);

    logic [FIB_W-1:0] ma_q;
    logic [FIB_W-1:0] ma_d;
    logic [FIB_W-1:0] mb_q;
    logic [FIB_W-1:0] mb_d;

    // Load puts the model in the state that follows an accepted 0.
    always_comb begin
        ma_d = ma_q;
        mb_d = mb_q;
        if (load) begin
            ma_d = {{(FIB_W-1){1'b0}}, 1'b1};
            mb_d = {{(FIB_W-1){1'b0}}, 1'b1};
        end else if (adv) begin
            {ma_d, mb_d} = fib_next(ma_q, mb_q);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ma_q <= '0;
            mb_q <= '0;
        end else begin
            ma_q <= ma_d;
            mb_q <= mb_d;
        end
    end

    assign mb = mb_q;

endmodule

// File: rtl/fib_checker.sv
// Stream checker for the wrapping 4-bit Fibonacci sequence 0,1,1,2,3,5,8.
// Ports: clk, rst (async active-low), din, valid in; locked, err,
// err_cnt, per_cnt, expected out.
module fib_checker
    import fib_pkg::*;
#(
    parameter int ERR_W        = 8,
    parameter int PER_W        = 8,
    parameter int LOCK_MATCHES = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [FIB_W-1:0] din,
    input  logic             valid,
    output logic             locked,
    output logic             err,
    output logic [ERR_W-1:0] err_cnt,
    output logic [PER_W-1:0] per_cnt,
    output logic [FIB_W-1:0] expected
);

    localparam logic [3:0] RUN_MAX = 4'hF;
    localparam logic [3:0] RUN_LOCK = 4'(LOCK_MATCHES);

    state_e           state_q;
    state_e           state_d;
    logic [3:0]       run_q;
    logic [3:0]       run_d;
    logic             locked_q;
    logic             locked_d;
    logic             err_q;
    logic             err_d;
    logic [ERR_W-1:0] err_cnt_q;
    logic [ERR_W-1:0] err_cnt_d;
    logic [PER_W-1:0] per_cnt_q;
    logic [PER_W-1:0] per_cnt_d;

    logic             ref_load;
    logic             ref_adv;
    logic [FIB_W-1:0] ref_mb;

    fib_ref_gen u_ref (
        .clk  (clk),
        .rst  (rst),
        .load (ref_load),
        .adv  (ref_adv),
        .mb   (ref_mb)
    );

    always_comb begin
        state_d   = state_q;
        run_d     = run_q;
        err_d     = 1'b0;
        err_cnt_d = err_cnt_q;
        per_cnt_d = per_cnt_q;
        ref_load  = 1'b0;
        ref_adv   = 1'b0;
        if (valid) begin
            unique case (state_q)
                HUNT: begin
                    if (din == '0) begin
                        ref_load = 1'b1;
                        run_d    = 4'd1;
                        state_d  = CHECK;
                    end
                end
                CHECK: begin
                    if (din == ref_mb) begin
                        ref_adv = 1'b1;
                        if (run_q != RUN_MAX) begin
                            run_d = run_q + 4'd1;
                        end
                        if (din == FIB_WRAP_TERM && !(&per_cnt_q)) begin
                            per_cnt_d = per_cnt_q + 1'b1;
                        end
                    end else begin
                        // The bad sample is dropped, not used to re-acquire.
                        err_d   = 1'b1;
                        run_d   = '0;
                        state_d = HUNT;
                        if (!(&err_cnt_q)) begin
                            err_cnt_d = err_cnt_q + 1'b1;
                        end
                    end
                end
                default: state_d = HUNT;
            endcase
        end
        locked_d = (state_d == CHECK) && (run_d >= RUN_LOCK);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= HUNT;
            run_q     <= '0;
            locked_q  <= 1'b0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
            per_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            run_q     <= run_d;
            locked_q  <= locked_d;
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
            per_cnt_q <= per_cnt_d;
        end
    end

    assign locked   = locked_q;
    assign err      = err_q;
    assign err_cnt  = err_cnt_q;
    assign per_cnt  = per_cnt_q;
    assign expected = (state_q == CHECK) ? ref_mb : '0;

endmodule

// File: tb/tb_fib_checker.sv
// Scoreboard bench for fib_checker: directed streams, queued expectations.
// A second instance with a 2-bit error counter covers saturation.
module tb_fib_checker;

    typedef struct {
        logic       err;
        logic [7:0] ec;
        logic [7:0] pc;
        logic       lk;
        logic [3:0] ex;
        logic [1:0] ec2;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] din = 4'd0;
    logic       valid = 1'b0;

    logic       locked;
    logic       err;
    logic [7:0] err_cnt;
    logic [7:0] per_cnt;
    logic [3:0] expected;

    logic       locked_s;
    logic       err_s;
    logic [1:0] err_cnt_s;
    logic [7:0] per_cnt_s;
    logic [3:0] expected_s;

    int n_chk = 0;
    int n_err = 0;
    int sat_pulses = 0;

    exp_t q[$];
    exp_t mon_e;

    logic [3:0] seq [7] = '{4'd0, 4'd1, 4'd1, 4'd2, 4'd3, 4'd5, 4'd8};

    logic       m_sync;
    int         m_pos;
    int         m_run;
    logic [7:0] m_ec;
    logic [7:0] m_pc;
    logic [1:0] m_ec2;

    fib_checker #(.ERR_W(8), .PER_W(8), .LOCK_MATCHES(7)) dut (
        .clk      (clk),
        .rst      (rst),
        .din      (din),
        .valid    (valid),
        .locked   (locked),
        .err      (err),
        .err_cnt  (err_cnt),
        .per_cnt  (per_cnt),
        .expected (expected)
    );

    fib_checker #(.ERR_W(2), .PER_W(8), .LOCK_MATCHES(7)) u_sat (
        .clk      (clk),
        .rst      (rst),
        .din      (din),
        .valid    (valid),
        .locked   (locked_s),
        .err      (err_s),
        .err_cnt  (err_cnt_s),
        .per_cnt  (per_cnt_s),
        .expected (expected_s)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (err_s) sat_pulses++;
        if (q.size() > 0) begin
            mon_e = q.pop_front();
            chk("sb err", int'(err), int'(mon_e.err));
            chk("sb err_cnt", int'(err_cnt), int'(mon_e.ec));
            chk("sb per_cnt", int'(per_cnt), int'(mon_e.pc));
            chk("sb locked", int'(locked), int'(mon_e.lk));
            chk("sb expected", int'(expected), int'(mon_e.ex));
            chk("sb err_cnt_sat", int'(err_cnt_s), int'(mon_e.ec2));
        end
    end

    task automatic model_reset();
        m_sync = 1'b0;
        m_pos  = 0;
        m_run  = 0;
        m_ec   = 8'd0;
        m_pc   = 8'd0;
        m_ec2  = 2'd0;
    endtask

    // Table-driven model: position in the 7-entry period, not ma/mb.
    task automatic model(input logic v, input logic [3:0] d, output exp_t e);
        e.err = 1'b0;
        if (v) begin
            if (!m_sync) begin
                if (d == 4'd0) begin
                    m_sync = 1'b1;
                    m_pos  = 1;
                    m_run  = 1;
                end
            end else if (d == seq[m_pos]) begin
                if (d == 4'd8 && m_pc != 8'hFF) m_pc = m_pc + 8'd1;
                m_pos = (m_pos == 6) ? 0 : m_pos + 1;
                if (m_run < 15) m_run++;
            end else begin
                e.err = 1'b1;
                if (m_ec != 8'hFF) m_ec = m_ec + 8'd1;
                if (m_ec2 != 2'd3) m_ec2 = m_ec2 + 2'd1;
                m_sync = 1'b0;
                m_run  = 0;
            end
        end
        e.ec  = m_ec;
        e.pc  = m_pc;
        e.ec2 = m_ec2;
        e.lk  = m_sync && (m_run >= 7);
        e.ex  = m_sync ? seq[m_pos] : 4'd0;
    endtask

    task automatic step(input logic v, input logic [3:0] d);
        exp_t e;
        valid = v;
        din   = d;
        model(v, d, e);
        @(posedge clk);
        q.push_back(e);
        #1;
    endtask

    // Drops reset between edges and checks the asynchronous clear.
    task automatic do_reset();
        @(negedge clk);
        #2;
        valid = 1'b0;
        rst   = 1'b0;
        #1;
        chk("rst locked", int'(locked), 0);
        chk("rst err", int'(err), 0);
        chk("rst err_cnt", int'(err_cnt), 0);
        chk("rst per_cnt", int'(per_cnt), 0);
        chk("rst expected", int'(expected), 0);
        chk("rst err_cnt_sat", int'(err_cnt_s), 0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        int sp0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("init locked", int'(locked), 0);
        chk("init expected", int'(expected), 0);
        chk("init err_cnt", int'(err_cnt), 0);
        rst = 1'b1;

        // Dense stream, three periods.
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 7; i++) begin
                step(1'b1, seq[i]);
                if (r == 0 && i == 5) chk("t1 not locked at 6", int'(locked), 0);
                if (r == 0 && i == 6) chk("t1 locked at 7", int'(locked), 1);
            end
        end
        chk("t1 per_cnt", int'(per_cnt), 3);
        chk("t1 err_cnt", int'(err_cnt), 0);

        // Junk in HUNT, then acquire.
        do_reset();
        step(1'b1, 4'd5);
        step(1'b1, 4'd3);
        chk("t2 hunt expected", int'(expected), 0);
        step(1'b1, 4'd0);
        chk("t2 expected after 0", int'(expected), 1);
        step(1'b1, 4'd1);
        step(1'b1, 4'd1);
        chk("t2 expected after 0,1,1", int'(expected), 2);
        chk("t2 err_cnt", int'(err_cnt), 0);

        // Corrupted 2 while locked, then re-lock.
        do_reset();
        for (int i = 0; i < 7; i++) step(1'b1, seq[i]);
        step(1'b1, 4'd0);
        step(1'b1, 4'd1);
        step(1'b1, 4'd1);
        step(1'b1, 4'd4);
        chk("t3 err pulse", int'(err), 1);
        chk("t3 err_cnt", int'(err_cnt), 1);
        chk("t3 locked drop", int'(locked), 0);
        chk("t3 expected hunt", int'(expected), 0);
        step(1'b1, 4'd3);
        chk("t3 err one cycle", int'(err), 0);
        step(1'b1, 4'd5);
        step(1'b1, 4'd8);
        chk("t3 tail ignored", int'(err_cnt), 1);
        for (int i = 0; i < 6; i++) step(1'b1, seq[i]);
        chk("t3 not relocked at 6", int'(locked), 0);
        step(1'b1, seq[6]);
        chk("t3 relocked at 7", int'(locked), 1);

        // Sparse valid with junk on idle cycles.
        do_reset();
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 7; i++) begin
                step(1'b1, seq[i]);
                step(1'b0, 4'(15 - i));
            end
        end
        chk("t4 per_cnt", int'(per_cnt), 2);
        chk("t4 locked", int'(locked), 1);
        chk("t4 err_cnt", int'(err_cnt), 0);

        // Five mismatches: 2-bit counter saturates at 3.
        do_reset();
        @(negedge clk);
        sp0 = sat_pulses;
        for (int k = 0; k < 5; k++) begin
            step(1'b1, 4'd0);
            step(1'b1, 4'd1);
            step(1'b1, 4'd7);
            step(1'b0, 4'd0);
        end
        @(negedge clk);
        chk("t5 sat err_cnt", int'(err_cnt_s), 3);
        chk("t5 wide err_cnt", int'(err_cnt), 5);
        chk("t5 sat err pulses", sat_pulses - sp0, 5);

        // Reset while locked mid-period.
        do_reset();
        for (int i = 0; i < 7; i++) step(1'b1, seq[i]);
        step(1'b1, 4'd0);
        step(1'b1, 4'd1);
        chk("t6 locked before rst", int'(locked), 1);
        do_reset();
        step(1'b1, 4'd1);
        chk("t6 no acquire on 1", int'(expected), 0);
        step(1'b1, 4'd0);
        chk("t6 reacquire", int'(expected), 1);

        valid = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("queue drained", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/fib_checker.md
# fib_checker

Stream checker for the 4-bit wrapping Fibonacci sequence our generator emits: 0, 1, 1, 2, 3, 5, 8, then back to 0, a period of 7. The checker samples a valid-qualified 4-bit stream and hunts for the sequence start. Once synchronised, it compares every sample against an internal reference model. It reports lock, per-sample error pulses, a saturating error count and a count of completed periods. It sits on the consumer side of the generator's output bus, for self-test and link monitoring.

## Interface
- ERR_W, 8: width of the error counter (saturating).
- PER_W, 8: width of the completed-period counter (saturating).
- LOCK_MATCHES, 7: consecutive matched samples required before `locked` asserts, range 1..15.
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous, active-low; clears all state immediately.
- din  in  4  sample under test.
- valid  in  1  din is sampled on this edge when high; ignored otherwise.
- locked  out  1  checker is synchronised and the match run has reached LOCK_MATCHES.
- err  out  1  one-cycle pulse flagging a mismatched sample.
- err_cnt  out  ERR_W  number of mismatches since reset, saturating at all-ones.
- per_cnt  out  PER_W  number of complete matched periods (a matched 8), saturating.
- expected  out  4  next value the checker expects; 0 while in HUNT.

## Operation
- Reference model: registers ma and mb use the generator's update rule; the expected value is mb.
  - Advance when mb[3]=1: ma←1, mb←0.
  - Advance otherwise: ma←ma+mb (mod 16), mb←ma.
- States:
  - HUNT: wait for a valid sample equal to 0. On such a sample, load ma←1, mb←1 (the post-advance state), set run←1 and go to CHECK. Non-zero valid samples are discarded without any error.
  - CHECK, valid && din==mb (match): advance the model and increment run, saturating at 15. If the matched value was 8, increment per_cnt (saturating).
  - CHECK, valid && din!=mb (mismatch): err←1 for one cycle, err_cnt increments (saturating), run←0, go to HUNT.
- The mismatching sample is not reused for acquisition, even if it is 0. The next valid 0 re-acquires.
- locked = (state==CHECK) && (run ≥ LOCK_MATCHES), registered.
- valid low: no state, model, counter or flag change, and err is 0.
- Saturation: at all-ones, err_cnt and per_cnt hold their value. err still pulses.

## Timing
- All outputs are registered, except `expected`, which is driven directly from the mb register and gated to 0 in HUNT.
- Latency: a sample presented with valid on edge N is reflected in err, err_cnt, per_cnt, locked and expected after edge N.
- err is high for exactly the one cycle following each mismatching sample. Back-to-back mismatches are not possible, because a mismatch returns to HUNT.
- Reset values: state=HUNT, ma=mb=0, run=0, locked=0, err=0, err_cnt=0, per_cnt=0, expected=0.
- Reset asserted mid-stream clears everything asynchronously. After release, the first valid 0 acquires.
- Streaming at full rate (valid held high) is supported, one sample per cycle with no stalls.

## Structure
- Shared package fib_pkg:
  - FIB_W=4 and FIB_WRAP_TERM=4'h8.
  - The state enum {HUNT, CHECK}.
  - A function fib_next(a, b) returning the {a, b} pair after one advance.
- One sub-module, fib_ref_gen: holds ma/mb, has load and advance enables, and outputs mb. The checker FSM and counters wrap it.

## Test plan
- Reset, then a full-rate stream 0,1,1,2,3,5,8 repeated ×3 → locked rises after the 7th matched sample (the first 8). Final state: per_cnt=3, err_cnt=0, err never high.
- Stream 5,3,0,1,1 → the 5 and 3 are ignored in HUNT with no err. Acquisition happens on the 0, expected=1 after it, and run reaches 3.
- Locked stream with the 2 corrupted to 4 → err pulses for one cycle and err_cnt=1. locked drops, expected=0, and the following 3,5,8 are ignored. Re-lock occurs 7 matches after the next 0.
- Stream with valid toggled 1,0,1,0 and junk on din during valid=0 → identical results to the dense stream, with no err.
- ERR_W=2 with 5 forced mismatches → err_cnt saturates at 3 and err pulses 5 times.
- Reset dropped while locked mid-period → all outputs 0 asynchronously before the next edge. Acquisition resumes after release.
